apb_master_interface: RTL and testbench
=======================================

# apb_master_interface

APB initiator for the floating-point co-processor: it turns single command requests (operand/instruction writes, result reads) from the host-side sequencer into APB transfers. Each transfer is one SETUP phase followed by an ACCESS phase held until `pready`. The block returns one response per request, carrying read data and a status code. It is the counterpart of the co-processor's APB slave interface and runs wholly in the `clk` domain.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum ACCESS cycles with `pready`=0 before the transfer is aborted; range 1..255.
- `MAX_RETRIES`, 2: number of re-issues after a `pslverr` response; range 0..7.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: a command is present.
- `req_ready` out 1: the block accepts a command this cycle.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 32: target address.
- `req_wdata` in 32: write data.
- `resp_valid` out 1: a response is held.
- `resp_ready` in 1: the consumer takes the response.
- `resp_rdata` out 32: read data; 0 for writes and for errored reads.
- `resp_status` out 2: 00 OK, 01 slave error, 10 timeout.
- `paddr` out 32, `pwdata` out 32, `pwrite` out 1, `psel` out 1, `penable` out 1: APB request signals.
- `prdata` in 32, `pready` in 1, `pslverr` in 1: APB response signals.

## Operation
- The state machine has four states: IDLE, SETUP, ACCESS, RESP. `rst` forces IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_write`/`req_addr`/`req_wdata` into `pwrite`/`paddr`/`pwdata`, clear the retry and wait counters, and go to SETUP.
- SETUP: `psel`=1, `penable`=0. Unconditionally go to ACCESS.
- ACCESS: `psel`=1, `penable`=1.
  - `pready`=1, `pslverr`=0: capture `prdata` (reads only; writes give 0), status 00, go to RESP.
  - `pready`=1, `pslverr`=1, retry count < MAX_RETRIES: increment the retry count, clear the wait counter, go to SETUP. This is a full re-issue with the same address and data.
  - `pready`=1, `pslverr`=1, retries exhausted: `resp_rdata`=0, status 01, go to RESP.
  - `pready`=0: increment the wait counter. When the counter reaches TIMEOUT, `resp_rdata`=0, status 10, go to RESP.
- RESP:
  - `psel`=`penable`=0, `resp_valid`=1.
  - `resp_rdata`/`resp_status` are held until `resp_ready`=1, then go to IDLE.
  - No new request is accepted while a response is pending; `req_ready`=0.
- `paddr`/`pwdata`/`pwrite` are registered. They stay stable from SETUP through the end of ACCESS, and they keep their value in RESP and IDLE until the next accept.
- `pslverr` is sampled only when `pready`=1 in ACCESS and ignored otherwise. `prdata` is ignored outside ACCESS with `pready`=1.
- The wait counter is 8 bits wide and saturates; it never wraps. The retry counter is 3 bits wide.

## Timing
- Reset values:
  - `psel`, `penable`, `pwrite`, `resp_valid`: 0.
  - `paddr`, `pwdata`, `resp_rdata`: 0.
  - `resp_status`: 00.
  - `req_ready`: 1 in the cycle after `rst` deasserts, since the state is IDLE.
- Accept at edge N gives SETUP in cycle N+1 and ACCESS in N+2. With zero-wait `pready`, `resp_valid` rises in N+3.
- Minimum period between accepts: 4 cycles, namely accept, SETUP, ACCESS, and a RESP consumed immediately; then IDLE.
- Each `pslverr` retry adds 2 cycles (SETUP + ACCESS).
- Timeout: `resp_valid` rises the cycle after the TIMEOUT-th consecutive `pready`=0 ACCESS cycle. With the default, the longest ACCESS is 16 cycles.
- A `pready`=1 in the same cycle the wait counter hits TIMEOUT counts as a completion; the timeout is not raised.
- `rst` mid-transfer drops `psel`/`penable` to 0 at the next edge and discards any pending response and the captured request.
- `resp_ready` asserted before `resp_valid` has no effect.

## Test plan
- Write 0x0000_0010 ← 0x3F80_0000 with zero-wait slave → SETUP then ACCESS, `paddr`/`pwdata` stable; `resp_valid` 3 cycles after accept with status 00, `resp_rdata`=0.
- Read 0x0000_0020 with slave holding `pready`=0 for 3 cycles, then `prdata`=0x4049_0FDB → ACCESS lasts 4 cycles; response 0x4049_0FDB with status 00.
- Read with `pslverr`=1 on every completion, MAX_RETRIES=2 → exactly 3 SETUP/ACCESS pairs; status 01, `resp_rdata`=0. Repeat with the error only on the first attempt → 2 pairs, status 00.
- Slave never asserts `pready`, TIMEOUT=16 → `penable` high exactly 16 cycles, then deasserted; status 10. Also `pready`=1 on the 16th cycle → status 00.
- Hold `resp_ready`=0 for 5 cycles with `req_valid` high → `req_ready`=0 and no `psel` throughout; the next transfer starts only after the response is taken.
- Assert `rst` during ACCESS → `psel`/`penable`/`resp_valid` are 0 the next cycle and `req_ready`=1 after release.

Source files
------------

// File: rtl/apb_master_interface.sv
// APB initiator for the floating-point co-processor: turns single host commands
// into APB SETUP/ACCESS transfers, with retry on slave error and an ACCESS timeout.
module apb_master_interface #(
    parameter int TIMEOUT     = 16,
    parameter int MAX_RETRIES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_status,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        pwrite,
    output logic        psel,
    output logic        penable,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);
    localparam logic [2:0] RETRY_L   = 3'(MAX_RETRIES);

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_SLVERR  = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    state_t      state_reg;
    logic [7:0]  wait_cnt_reg;
    logic [2:0]  retry_cnt_reg;
    logic [7:0]  wait_cnt_next;

    // Saturating increment: the counter must never wrap back below TIMEOUT.
    assign wait_cnt_next = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg : wait_cnt_reg + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            retry_cnt_reg <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_status   <= STATUS_OK;
            paddr         <= '0;
            pwdata        <= '0;
            pwrite        <= 1'b0;
            psel          <= 1'b0;
            penable       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        paddr         <= req_addr;
                        pwdata        <= req_wdata;
                        pwrite        <= req_write;
                        wait_cnt_reg  <= '0;
                        retry_cnt_reg <= '0;
                        req_ready     <= 1'b0;
                        psel          <= 1'b1;
                        penable       <= 1'b0;
                        state_reg     <= SETUP;
                    end
                end

                SETUP: begin
                    penable   <= 1'b1;
                    state_reg <= ACCESS;
                end

                ACCESS: begin
                    if (pready) begin
                        // A completion wins over a timeout reached in the same cycle.
                        if (!pslverr) begin
                            resp_rdata  <= pwrite ? 32'd0 : prdata;
                            resp_status <= STATUS_OK;
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            resp_valid  <= 1'b1;
                            state_reg   <= RESP;
                        end else if (retry_cnt_reg < RETRY_L) begin
                            retry_cnt_reg <= retry_cnt_reg + 3'd1;
                            wait_cnt_reg  <= '0;
                            penable       <= 1'b0;
                            state_reg     <= SETUP;
                        end else begin
                            resp_rdata  <= '0;
                            resp_status <= STATUS_SLVERR;
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            resp_valid  <= 1'b1;
                            state_reg   <= RESP;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                        if (wait_cnt_next >= TIMEOUT_L) begin
                            resp_rdata  <= '0;
                            resp_status <= STATUS_TIMEOUT;
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            resp_valid  <= 1'b1;
                            state_reg   <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_reg  <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_interface.sv
// Scoreboard bench for apb_master_interface: directed commands against a small
// configurable APB slave model; responses are checked by a separate monitor.
module tb_apb_master_interface;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_status;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int tests = 0;
    int fails = 0;

    // Slave model configuration and observation counters
    int          slv_wait  = 0;
    int          slv_errs  = 0;
    bit          slv_never = 1'b0;
    logic [31:0] slv_data  = '0;
    int          acc_cycle = 0;
    int          setup_cnt = 0;
    int          penable_cnt = 0;
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;
    logic        exp_write = 1'b0;

    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    apb_master_interface #(
        .TIMEOUT    (16),
        .MAX_RETRIES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_status(resp_status),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    // Slave model: drives the response half-way through each cycle
    always @(negedge clk) begin
        if (psel === 1'b1 && penable === 1'b0) begin
            setup_cnt++;
            acc_cycle = 0;
        end
        if (psel === 1'b1) begin
            tests++;
            if (paddr !== exp_addr || pwdata !== exp_wdata || pwrite !== exp_write) begin
                fails++;
                $display("FAIL apb_stable: got addr=%h wdata=%h write=%b, want addr=%h wdata=%h write=%b",
                         paddr, pwdata, pwrite, exp_addr, exp_wdata, exp_write);
            end
        end
        if (psel === 1'b1 && penable === 1'b1) begin
            penable_cnt++;
            if (!slv_never && acc_cycle >= slv_wait) begin
                pready  = 1'b1;
                prdata  = slv_data;
                pslverr = (slv_errs > 0);
                if (slv_errs > 0) slv_errs--;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b1;
                prdata  = 32'hBAD0_BAD0;
            end
            acc_cycle++;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b1;
            prdata  = 32'hDEAD_BEEF;
        end
    end

    // Response monitor: pops the expected response on each handshake
    always @(negedge clk) begin
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            logic [33:0] e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL resp_unexpected: got rdata=%h status=%b, want no response",
                         resp_rdata, resp_status);
            end else begin
                e = exp_q.pop_front();
                if (resp_rdata !== e[33:2] || resp_status !== e[1:0]) begin
                    fails++;
                    $display("FAIL resp: got rdata=%h status=%b, want rdata=%h status=%b",
                             resp_rdata, resp_status, e[33:2], e[1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        exp_addr  = addr;
        exp_wdata = wdata;
        exp_write = wr;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
    endtask

    // Returns the number of cycles from accept edge to resp_valid (caller is at accept edge + 1)
    task automatic wait_resp(output int lat);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_req(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic [1:0] exp_status, input int exp_setups,
                           input int exp_pen, input int exp_lat);
        int lat;
        setup_cnt   = 0;
        penable_cnt = 0;
        start_req(wr, addr, wdata);
        check({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
        exp_q.push_back({exp_rdata, exp_status});
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({name, " setup_phase"}, {30'd0, psel, penable}, 32'd2);
        wait_resp(lat);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({name, " setups"}, 32'(setup_cnt), 32'(exp_setups));
        check({name, " penable_cycles"}, 32'(penable_cnt), 32'(exp_pen));
        check({name, " idle_after"}, {29'd0, req_ready, psel, resp_valid}, 32'd4);
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("reset ctrl", {27'd0, req_ready, psel, penable, pwrite, resp_valid}, 32'h10);
        check("reset paddr", paddr, 32'd0);
        check("reset pwdata", pwdata, 32'd0);
        check("reset rdata", resp_rdata, 32'd0);
        check("reset status", {30'd0, resp_status}, 32'd0);

        // Zero-wait write: response 3 cycles after accept, rdata 0
        slv_wait = 0; slv_errs = 0; slv_never = 0; slv_data = 32'h1234_5678;
        run_req("wr_zero_wait", 1'b1, 32'h0000_0010, 32'h3F80_0000, 32'd0, 2'b00, 1, 1, 3);

        // Read with 3 wait states
        slv_wait = 3; slv_data = 32'h4049_0FDB;
        run_req("rd_wait3", 1'b0, 32'h0000_0020, 32'h0, 32'h4049_0FDB, 2'b00, 1, 4, 6);

        // Error on every completion: 3 attempts, status 01
        slv_wait = 0; slv_errs = 10; slv_data = 32'hCAFE_F00D;
        run_req("rd_err_all", 1'b0, 32'h0000_0030, 32'h0, 32'd0, 2'b01, 3, 3, 7);

        // Error on first attempt only
        slv_errs = 1; slv_data = 32'h0BAD_CAFE;
        run_req("rd_err_once", 1'b0, 32'h0000_0034, 32'h0, 32'h0BAD_CAFE, 2'b00, 2, 2, 5);

        // Slave never ready: 16 ACCESS cycles, timeout
        slv_errs = 0; slv_never = 1; slv_data = 32'h1111_2222;
        run_req("rd_timeout", 1'b0, 32'h0000_0040, 32'h0, 32'd0, 2'b10, 1, 16, 18);

        // Ready on the 16th ACCESS cycle: completion beats timeout
        slv_never = 0; slv_wait = 15; slv_data = 32'h5555_AAAA;
        run_req("rd_ready16", 1'b0, 32'h0000_0044, 32'h0, 32'h5555_AAAA, 2'b00, 1, 16, 18);

        // Back-pressure: response held, new request must wait
        slv_wait = 0; slv_data = 32'h0000_00A5;
        setup_cnt = 0;
        start_req(1'b0, 32'h0000_0050, 32'h0);
        exp_q.push_back({32'h0000_00A5, 2'b00});
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(lat);
        check("bp latency", 32'(lat), 32'd3);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0060;
        req_wdata = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp hold", {29'd0, req_ready, psel, resp_valid}, 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        exp_addr = 32'h0000_0060; exp_wdata = 32'h4000_0000; exp_write = 1'b1;
        check("bp released", {29'd0, req_ready, psel, resp_valid}, 32'd4);
        exp_q.push_back({32'd0, 2'b00});
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp second setup", {30'd0, psel, penable}, 32'd2);
        wait_resp(lat);
        check("bp second latency", 32'(lat), 32'd3);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp setups", 32'(setup_cnt), 32'd2);

        // Reset during ACCESS
        slv_never = 1;
        start_req(1'b1, 32'h0000_0070, 32'h7777_0000);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst pre access", {30'd0, psel, penable}, 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst drops", {29'd0, psel, penable, resp_valid}, 32'd0);
        check("rst paddr cleared", paddr, 32'd0);
        rst = 1'b0;
        slv_never = 0;
        @(posedge clk); #1;
        check("rst req_ready", {31'd0, req_ready}, 32'd1);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
